// File: rtl/button_wb_writer_pkg.sv
// Shared types and helpers for the push-button to Wishbone LED writer.
package button_wb_writer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } btn_wb_state_t;

  localparam int SHADOW_W    = 8;
  localparam int SYNC_STAGES = 2;
  localparam int WB_ADR_W    = 32;
  localparam int WB_DAT_W    = 32;
  localparam int WB_SEL_W    = WB_DAT_W / 8;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Low nibble toggles per pressed button; high nibble counts presses modulo 16.
  function automatic logic [SHADOW_W-1:0] shadow_apply(input logic [SHADOW_W-1:0] s,
                                                       input logic [3:0]          p);
    logic [3:0] hi;
    hi = s[7:4] + {1'b0, popcount4(p)};
    return {hi, s[3:0] ^ p};
  endfunction

endpackage

// File: rtl/wishbone.sv
// Pipelined Wishbone bus bundle; the controller modport is the bus-master view.
interface wishbone;
  import button_wb_writer_pkg::*;

  logic                clk_i;
  logic                rst_i;
  logic                cyc_o;
  logic                stb_o;
  logic                we_o;
  logic [WB_ADR_W-1:0] adr_o;
  logic [WB_DAT_W-1:0] dat_o;
  logic [WB_SEL_W-1:0] sel_o;
  logic                ack_i;
  logic                stall_i;
  logic                err_i;
  logic                rty_i;

  modport controller (
    input  clk_i, rst_i, ack_i, stall_i, err_i, rty_i,
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );

endinterface

// File: rtl/button_wb_writer_debouncer.sv
// One button: 2-flop synchroniser, stability counter and registered rising-edge pulse.
module button_wb_writer_debouncer
  import button_wb_writer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic debounced_o,
  output logic rise_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   rise_q, rise_d;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (level == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = level;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
    end
  end

  assign debounced_o = deb_q;
  assign rise_o      = rise_q;

endmodule

// File: rtl/button_wb_writer.sv
// Debounced button presses update an 8-bit LED shadow that is pushed out by single Wishbone writes.
// Define BUTTON_WB_TIMEOUT_EN to abort and retry writes that get no response within TIMEOUT_CYCLES.
module button_wb_writer
  import button_wb_writer_pkg::*;
#(
  parameter int          NUM_BUTTONS     = 4,
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] WB_ADDR         = 32'h0,
  parameter int          TIMEOUT_CYCLES  = 256
) (
  wishbone.controller         wb,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                busy
);

  logic [NUM_BUTTONS-1:0] rise, level, press_evt;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_wb_writer_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk        (wb.clk_i),
      .rst        (wb.rst_i),
      .raw_i      (buttons[i]),
      .debounced_o(level[i]),
      .rise_o     (rise[i])
    );
  end

  // The pulse is registered alongside the level, so both are high together.
  assign press_evt = rise & level;

  btn_wb_state_t       state_q, state_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                dirty_q, dirty_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;

`ifdef BUTTON_WB_TIMEOUT_EN
  localparam int               TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      timeout_count_q, timeout_count_d;
  logic [7:0]      timeout_count;
  logic            timeout_pulse;
  assign timeout_count = timeout_count_q;
`endif

  always_comb begin
    state_d  = state_q;
    dirty_d  = dirty_q;
    dat_d    = dat_q;
    shadow_d = shadow_apply(shadow_q, press_evt);

    case (state_q)
      IDLE: begin
        if ((|press_evt) || dirty_q) begin
          state_d = REQ;
          dat_d   = {{(WB_DAT_W-SHADOW_W){1'b0}}, shadow_d};
          dirty_d = 1'b0;
        end
      end
      REQ: begin
        if (|press_evt) dirty_d = 1'b1;
        if (!wb.stall_i) begin
          if (wb.ack_i) begin
            state_d = IDLE;
          end else if (wb.err_i || wb.rty_i) begin
            state_d = IDLE;
            dirty_d = 1'b1;
          end else begin
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (|press_evt) dirty_d = 1'b1;
        if (wb.ack_i) begin
          state_d = IDLE;
        end else if (wb.err_i || wb.rty_i) begin
          state_d = IDLE;
          dirty_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef BUTTON_WB_TIMEOUT_EN
    to_cnt_d        = '0;
    timeout_pulse   = 1'b0;
    timeout_count_d = timeout_count_q;
    // Only an unanswered cycle ages; any termination restarts the count.
    if (state_q != IDLE && state_d != IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_pulse = 1'b1;
        state_d       = IDLE;
        dirty_d       = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
    if (timeout_pulse && timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
`endif
  end

  always_ff @(posedge wb.clk_i) begin
    if (wb.rst_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      dirty_q  <= 1'b0;
      dat_q    <= '0;
`ifdef BUTTON_WB_TIMEOUT_EN
      to_cnt_q        <= '0;
      timeout_count_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      dat_q    <= dat_d;
`ifdef BUTTON_WB_TIMEOUT_EN
      to_cnt_q        <= to_cnt_d;
      timeout_count_q <= timeout_count_d;
`endif
    end
  end

  assign wb.cyc_o = (state_q != IDLE);
  assign wb.stb_o = (state_q == REQ);
  assign wb.we_o  = (state_q != IDLE);
  assign wb.adr_o = WB_ADDR;
  assign wb.dat_o = dat_q;
  assign wb.sel_o = '1;
  assign busy     = (state_q != IDLE) || dirty_q;

endmodule
